// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: stream FIFO controller wrapped around an external dual-port RAM.
// One RAM port writes, the other reads. A 2-entry output stage hides the RAM's
// 1-cycle read latency, so the stream runs at one word per cycle in both
// directions. Total capacity is DEPTH words in RAM plus 2 in the output stage.
module ram_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 4,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [ADDR+1:0]  count,
  output logic             ram_wen,
  output logic             ram_we,
  output logic [ADDR-1:0]  ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_ren,
  output logic [ADDR-1:0]  ram_raddr,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam int PW = ADDR + 1;

  // Pointers carry one extra wrap bit so that full and empty are distinguishable.
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       stage_cnt_q, stage_cnt_d;
  logic [WIDTH-1:0] stage0_q, stage0_d;
  logic [WIDTH-1:0] stage1_q, stage1_d;
  logic [ADDR+1:0]  count_q, count_d;

  logic [PW-1:0]    mem_cnt_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             ren_s;
  logic [2:0]       occ_s;
  logic [1:0]       cnt_after_pop_s;

  // Handshake decode and RAM port drive, all from registered state plus inputs.
  always_comb begin
    mem_cnt_s = wptr_q - rptr_q;
    full_s    = (mem_cnt_s == PW'(DEPTH));
    s_ready   = !full_s && rst_n;
    // A flush in the same cycle discards the incoming word.
    push_s    = s_valid && s_ready && !flush;
    m_valid   = (stage_cnt_q != 2'd0);
    pop_s     = m_valid && m_ready;
    // Output-stage occupancy once this cycle's pop leaves and any in-flight read lands.
    occ_s     = {1'b0, stage_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    // Reads are issued only when the word they fetch is guaranteed a stage slot.
    ren_s     = (mem_cnt_s != {PW{1'b0}}) && !flush && (occ_s < 3'd2);

    ram_wen   = push_s;
    ram_we    = push_s;
    ram_waddr = wptr_q[ADDR-1:0];
    ram_wdata = s_data;
    ram_ren   = ren_s;
    ram_raddr = rptr_q[ADDR-1:0];

    m_data    = stage0_q;
    count     = count_q;
  end

  // Next-state for pointers, in-flight flag, output stage and occupancy count.
  always_comb begin
    wptr_d          = wptr_q;
    rptr_d          = rptr_q;
    inflight_d      = 1'b0;
    stage_cnt_d     = stage_cnt_q;
    stage0_d        = stage0_q;
    stage1_d        = stage1_q;
    count_d         = count_q;
    cnt_after_pop_s = stage_cnt_q - {1'b0, pop_s};

    if (flush) begin
      // Everything is dropped, including a read returning this cycle.
      wptr_d      = {PW{1'b0}};
      rptr_d      = {PW{1'b0}};
      inflight_d  = 1'b0;
      stage_cnt_d = 2'd0;
      stage0_d    = {WIDTH{1'b0}};
      stage1_d    = {WIDTH{1'b0}};
      count_d     = {(ADDR+2){1'b0}};
    end else begin
      if (push_s) begin
        wptr_d = wptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        wptr_d = wptr_q;
      end

      if (ren_s) begin
        rptr_d = rptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rptr_d = rptr_q;
      end
      inflight_d = ren_s;

      // Pop shifts entry 1 forward; the returning read fills the first free slot.
      if (pop_s) begin
        stage0_d = stage1_q;
      end else begin
        stage0_d = stage0_q;
      end

      if (inflight_q) begin
        if (cnt_after_pop_s == 2'd0) begin
          stage0_d = ram_rdata;
        end else begin
          stage1_d = ram_rdata;
        end
      end else begin
        stage1_d = stage1_q;
      end
      stage_cnt_d = cnt_after_pop_s + {1'b0, inflight_q};

      count_d = count_q + {{(ADDR+1){1'b0}}, push_s} - {{(ADDR+1){1'b0}}, pop_s};
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= {PW{1'b0}};
      rptr_q      <= {PW{1'b0}};
      inflight_q  <= 1'b0;
      stage_cnt_q <= 2'd0;
      stage0_q    <= {WIDTH{1'b0}};
      stage1_q    <= {WIDTH{1'b0}};
      count_q     <= {(ADDR+2){1'b0}};
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      inflight_q  <= inflight_d;
      stage_cnt_q <= stage_cnt_d;
      stage0_q    <= stage0_d;
      stage1_q    <= stage1_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl: behavioural RAM, queue-based reference model,
// a vector table for the single-word latency case, directed corner sequences
// and randomized valid/ready traffic.
module tb_ram_fifo_ctrl;

  localparam int WIDTH = 8;
  localparam int ADDR  = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic [ADDR+1:0]  count;
  logic             ram_wen;
  logic             ram_we;
  logic [ADDR-1:0]  ram_waddr;
  logic [WIDTH-1:0] ram_wdata;
  logic             ram_ren;
  logic [ADDR-1:0]  ram_raddr;
  logic [WIDTH-1:0] ram_rdata;

  ram_fifo_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count),
    .ram_wen(ram_wen), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Dual-port RAM with registered read data (1-cycle latency).
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wen && ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: the FIFO contents as an ordered queue.
  logic [WIDTH-1:0] q[$];
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;
  int               starve     = 0;

  // Values sampled in the most recent step.
  logic             smp_ren, smp_mv, smp_sr, smp_push, smp_pop;
  logic [WIDTH-1:0] smp_md;
  int               smp_cnt;

  // One clock cycle: drive inputs, sample at the falling edge, check, update model.
  task automatic step(input logic sv, input logic [WIDTH-1:0] sd, input logic mr, input logic fl);
    logic [WIDTH-1:0] tmp;
    s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
    @(negedge clk);
    smp_ren = ram_ren; smp_mv = m_valid; smp_md = m_data;
    smp_cnt = int'(count); smp_sr = s_ready;
    chk("count_vs_model", int'(count), q.size());
    if (m_valid) begin
      chk("head_present", int'(q.size() > 0), 1);
      if (q.size() > 0) chk("head_data", int'(m_data), int'(q[0]));
    end
    if (!s_ready) chk("sready_low_only_when_full", int'(q.size() >= DEPTH), 1);
    if (prev_stall) begin
      chk("stall_valid", int'(m_valid), 1);
      chk("stall_data", int'(m_data), int'(prev_data));
    end
    if (q.size() != 0 && !m_valid) starve++;
    else starve = 0;
    chk("no_starvation", int'(starve <= 3), 1);
    smp_push   = sv && s_ready && !fl;
    smp_pop    = m_valid && mr;
    prev_stall = m_valid && !mr && !fl;
    prev_data  = m_data;
    if (fl) begin
      q.delete();
    end else begin
      if (smp_pop && q.size() > 0) tmp = q.pop_front();
      if (smp_push) q.push_back(sd);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic             sv;
    logic [WIDTH-1:0] sd;
    logic             mr;
    logic             fl;
    logic             e_ren;
    logic             e_mv;
    logic [WIDTH-1:0] e_md;
    int               e_cnt;
    logic             e_sr;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, pops, first, last, drops, pushed, got;

    // Single-word latency: push 0xA5 in cycle 0, ready always high.
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1};

    // Reset state, with s_valid asserted to show nothing is written.
    s_valid = 1'b1;
    #2;
    chk("rst_sready", int'(s_ready), 0);
    chk("rst_mvalid", int'(m_valid), 0);
    chk("rst_mdata", int'(m_data), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_wen", int'(ram_wen), 0);
    chk("rst_ren", int'(ram_ren), 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_sready", int'(s_ready), 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      step(tbl[i].sv, tbl[i].sd, tbl[i].mr, tbl[i].fl);
      chk($sformatf("tbl%0d_ren", i), int'(smp_ren), int'(tbl[i].e_ren));
      chk($sformatf("tbl%0d_mvalid", i), int'(smp_mv), int'(tbl[i].e_mv));
      if (tbl[i].e_mv) chk($sformatf("tbl%0d_mdata", i), int'(smp_md), int'(tbl[i].e_md));
      chk($sformatf("tbl%0d_count", i), smp_cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_sready", i), int'(smp_sr), int'(tbl[i].e_sr));
    end

    // Fill with the sink stalled: 20 words offered once each, 18 fit.
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (smp_push) acc++;
      if (i >= 18) chk("fill_sready_low", int'(smp_sr), 0);
    end
    chk("fill_accepted", acc, 18);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fill_count", smp_cnt, 18);
    chk("fill_sready", int'(smp_sr), 0);
    pops = 0; first = -1; last = -1;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (smp_pop) begin
        if (first < 0) first = i;
        last = i;
        pops++;
      end
    end
    chk("drain_pops", pops, 18);
    chk("drain_no_gaps", last - first, 17);
    chk("drain_mvalid_end", int'(smp_mv), 0);

    // Continuous streaming of 40 words, wrapping the pointers twice.
    pops = 0; first = -1; last = -1; drops = 0;
    for (int i = 0; i < 45; i++) begin
      step(1'(i < 40), 8'(i), 1'b1, 1'b0);
      if (i < 40 && !smp_sr) drops++;
      if (smp_pop) begin
        if (first < 0) first = i;
        last = i;
        pops++;
      end
    end
    chk("stream_sready_drops", drops, 0);
    chk("stream_pops", pops, 40);
    chk("stream_first_pop", first, 3);
    chk("stream_last_pop", last, 42);

    // Randomized valid/ready traffic until 200 words have passed through.
    pushed = 0;
    for (int c = 0; c < 4000 && (pushed < 200 || q.size() > 0); c++) begin
      step(1'(pushed < 200 && $urandom_range(0, 99) < 60), 8'($urandom),
           1'($urandom_range(0, 99) < 55), 1'b0);
      if (smp_push) pushed++;
    end
    chk("random_pushed", pushed, 200);
    chk("random_drained", q.size(), 0);

    // Flush while a read is in flight.
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush_pre_count", smp_cnt, 6);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_pre_ren", int'(smp_ren), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush_cycle_count", smp_cnt, 5);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush_after_count", smp_cnt, 0);
    chk("flush_after_mvalid", int'(smp_mv), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush_late_data_ignored", int'(smp_mv), 0);
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    got = 0;
    for (int i = 0; i < 6 && got == 0; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (smp_mv) begin
        got = 1;
        chk("flush_next_word", int'(smp_md), 32'h3C);
      end
    end
    chk("flush_next_word_seen", got, 1);

    // Asynchronous reset between clock edges with 7 words held.
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("areset_pre_count", smp_cnt, 7);
    #2;
    rst_n = 1'b0;
    s_valid = 1'b1;
    #1;
    chk("areset_mvalid", int'(m_valid), 0);
    chk("areset_count", int'(count), 0);
    chk("areset_sready", int'(s_ready), 0);
    chk("areset_wen", int'(ram_wen), 0);
    chk("areset_ren", int'(ram_ren), 0);
    q.delete();
    prev_stall = 1'b0;
    starve = 0;
    @(negedge clk);
    rst_n = 1'b1;
    s_valid = 1'b0;
    #1;
    chk("areset_release_sready", int'(s_ready), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("areset_no_stale", int'(smp_mv), 0);
    end
    step(1'b1, 8'h99, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("areset_final_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
